lsu_mem_stage: RTL and testbench

- Memory-stage load/store unit of the pipelined RV32I core.
- Takes the MEM-stage access (address, store data, funct3) and runs a req/ack handshake to data memory.
- Stalls the pipeline while an access is outstanding.
- Delivers the aligned, sign/zero-extended load word `rd_dm`, which the writeback selector consumes as its load-data input.

---
 rtl/lsu_mem_stage.sv | 211 +++++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: memory-stage load/store unit for the pipelined RV32I core.
// Decodes the MEM-stage access, checks alignment/legality, runs a single
// outstanding req/ack transaction to data memory, stalls the pipeline while
// that transaction is in flight and returns the extended load word in rd_dm.
module lsu_mem_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] wdata,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [N-1:0] dmem_addr,
  output logic [N-1:0] dmem_wdata,
  output logic [3:0]   dmem_be,
  input  logic         dmem_ack,
  input  logic [N-1:0] dmem_rdata,
  output logic [N-1:0] rd_dm,
  output logic         stall,
  output logic         lsu_done,
  output logic         access_fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic         access;
  logic         misaligned;
  logic         illegal;
  logic         fault;
  logic         issue;
  logic         complete;

  logic [3:0]   lane_be;
  logic [N-1:0] lane_wdata;

  logic [2:0]   lat_funct3;
  logic [1:0]   lat_offset;
  logic         lat_load;

  logic [7:0]   byte_sel;
  logic [15:0]  half_sel;
  logic [N-1:0] load_ext;

  // Classify the live MEM-stage slot: is it a memory access, and is it legal.
  always_comb begin
    access     = valid_in & (mem_read | mem_write);
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = addr[0];
      3'b010:         misaligned = (addr[1:0] != 2'b00);
      default:        misaligned = 1'b0;
    endcase
    case (funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = mem_write;
      default:                illegal = 1'b1;
    endcase
    if (mem_read && mem_write) begin
      illegal = 1'b1;
    end
    fault = access & (misaligned | illegal);
  end

  // Handshake qualifiers: a clean access is launched only from IDLE, and a
  // transaction retires only on an ack seen while the request is live.
  always_comb begin
    issue    = (state == IDLE) & access & ~fault;
    complete = (state == BUSY) & dmem_ack;
  end

  // Store lane steering: replicate the store data across the word and pick
  // the byte enables that match the size and low address bits.
  always_comb begin
    lane_be    = 4'b0000;
    lane_wdata = wdata;
    case (funct3[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << addr[1:0];
        lane_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        lane_be    = addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata[15:0]}};
      end
      2'b10: begin
        lane_be    = 4'b1111;
        lane_wdata = wdata;
      end
      default: begin
        lane_be    = 4'b0000;
        lane_wdata = wdata;
      end
    endcase
  end

  // Load extraction uses the offset and size captured at issue, because the
  // live inputs may already describe a different instruction by ack time.
  always_comb begin
    byte_sel = dmem_rdata[7:0];
    case (lat_offset)
      2'd0: byte_sel = dmem_rdata[7:0];
      2'd1: byte_sel = dmem_rdata[15:8];
      2'd2: byte_sel = dmem_rdata[23:16];
      2'd3: byte_sel = dmem_rdata[31:24];
      default: byte_sel = dmem_rdata[7:0];
    endcase
    half_sel = lat_offset[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (lat_funct3)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_ext = dmem_rdata;
      3'b100:  load_ext = {24'b0, byte_sel};
      3'b101:  load_ext = {16'b0, half_sel};
      default: load_ext = dmem_rdata;
    endcase
  end

  // Next-state logic: DONE always returns to IDLE so the same instruction,
  // still visible on the inputs during DONE, is never issued twice.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (issue) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; reset abandons any outstanding transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Memory-side request registers: loaded at issue, held steady through BUSY,
  // and the request/strobes released on the ack edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= 4'b0000;
      lat_funct3 <= 3'b000;
      lat_offset <= 2'b00;
      lat_load   <= 1'b0;
    end else if (issue) begin
      dmem_req   <= 1'b1;
      dmem_we    <= mem_write;
      dmem_addr  <= {addr[N-1:2], 2'b00};
      dmem_wdata <= lane_wdata;
      dmem_be    <= lane_be;
      lat_funct3 <= funct3;
      lat_offset <= addr[1:0];
      lat_load   <= mem_read;
    end else if (complete) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= 4'b0000;
    end
  end

  // Load result register: only a completing load updates it, so stores and
  // faulting accesses leave the previous load value visible to writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_dm <= '0;
    end else if (complete && lat_load) begin
      rd_dm <= load_ext;
    end
  end

  // Pipeline-facing status: stall covers the issue cycle and every BUSY
  // cycle, and the DONE cycle both releases the stall and pulses lsu_done.
  always_comb begin
    stall        = issue | (state == BUSY);
    lsu_done     = (state == DONE);
    access_fault = fault;
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed and randomized checks of lsu_mem_stage against
// an arithmetic reference model of alignment, lane steering and extension.
module tb_lsu_mem_stage;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] rd_dm;
  logic        stall;
  logic        lsu_done;
  logic        access_fault;

  int checks;
  int failures;
  logic [31:0] exp_rd;

  lsu_mem_stage #(.N(32)) dut (
    .clk(clk),
    .rst(rst),
    .valid_in(valid_in),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .funct3(funct3),
    .addr(addr),
    .wdata(wdata),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be),
    .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .rd_dm(rd_dm),
    .stall(stall),
    .lsu_done(lsu_done),
    .access_fault(access_fault)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit modelFault(input bit v, input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
    if (!(v && (rd || wr))) return 1'b0;
    if (rd && wr) return 1'b1;
    if (!(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
    if (wr && (f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) return 1'b1;
    if (f3 == 3'd2 && (a % 4 != 0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [31:0] a);
    int off;
    off = a % 4;
    if (f3 == 3'd0) return 4'(1 << off);
    if (f3 == 3'd1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3 == 3'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata);
    logic [31:0] b;
    logic [31:0] h;
    b = (rdata >> (8 * (a % 4))) & 32'hFF;
    h = (rdata >> (8 * (a % 4))) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd1: return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd4: return b;
      3'd5: return h;
      default: return rdata;
    endcase
  endfunction

  // Drives one MEM-stage slot starting at a negedge, plays the memory with
  // the given ack delay, and checks every cycle up to the following IDLE.
  task automatic applyStimulus(input string tag, input bit v, input bit rd, input bit wr,
                               input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] rdata, input int delay);
    bit acc;
    bit flt;
    int stalls;
    valid_in  = v;
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    dmem_ack  = 1'b0;
    #1;
    acc = v && (rd || wr);
    flt = modelFault(v, rd, wr, f3, a);
    checkOutput({tag, ".fault"}, access_fault, flt);
    checkOutput({tag, ".stall_issue"}, stall, acc && !flt);
    if (!acc || flt) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, ".noreq"}, dmem_req, 1'b0);
      checkOutput({tag, ".nodone"}, lsu_done, 1'b0);
      checkOutput({tag, ".rd_kept"}, rd_dm, exp_rd);
      valid_in = 1'b0;
    end else begin
      stalls = stall ? 1 : 0;
      @(posedge clk);
      for (int k = 1; k <= delay; k++) begin
        @(negedge clk);
        if (stall) stalls++;
        checkOutput({tag, ".req"}, dmem_req, 1'b1);
        checkOutput({tag, ".we"}, dmem_we, wr);
        checkOutput({tag, ".addr"}, dmem_addr, a & 32'hFFFF_FFFC);
        checkOutput({tag, ".busy_done"}, lsu_done, 1'b0);
        if (wr) begin
          checkOutput({tag, ".be"}, dmem_be, modelBe(f3, a));
          checkOutput({tag, ".wdata"}, dmem_wdata, modelWdata(f3, wd));
        end
        if (k == delay) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdata;
        end else begin
          dmem_rdata = $urandom;
        end
        @(posedge clk);
      end
      @(negedge clk);
      dmem_ack   = 1'b0;
      dmem_rdata = $urandom;
      if (rd) exp_rd = modelLoad(f3, a, rdata);
      checkOutput({tag, ".done"}, lsu_done, 1'b1);
      checkOutput({tag, ".stall_done"}, stall, 1'b0);
      checkOutput({tag, ".req_drop"}, dmem_req, 1'b0);
      checkOutput({tag, ".we_drop"}, dmem_we, 1'b0);
      checkOutput({tag, ".be_drop"}, dmem_be, 4'b0000);
      checkOutput({tag, ".rd_dm"}, rd_dm, exp_rd);
      checkOutput({tag, ".stall_cycles"}, 32'(stalls), 32'(delay + 1));
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, ".no_reissue"}, dmem_req, 1'b0);
      checkOutput({tag, ".done_once"}, lsu_done, 1'b0);
    end
  endtask

  // Directed test-plan steps, a mid-access reset, then randomized accesses.
  initial begin
    bit v;
    bit rd;
    bit wr;
    logic [2:0] f3;
    logic [31:0] a;
    checks     = 0;
    failures   = 0;
    exp_rd     = 32'h0;
    rst        = 1'b1;
    valid_in   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    funct3     = 3'b000;
    addr       = 32'h0;
    wdata      = 32'h0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.req", dmem_req, 1'b0);
    checkOutput("reset.we", dmem_we, 1'b0);
    checkOutput("reset.addr", dmem_addr, 32'h0);
    checkOutput("reset.wdata", dmem_wdata, 32'h0);
    checkOutput("reset.be", dmem_be, 4'b0000);
    checkOutput("reset.rd_dm", rd_dm, 32'h0);
    checkOutput("reset.done", lsu_done, 1'b0);
    checkOutput("reset.stall", stall, 1'b0);
    rst = 1'b0;

    applyStimulus("lb",  1, 1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF_FFFF, 1);
    checkOutput("lb.const", rd_dm, 32'hFFFF_FF80);
    applyStimulus("lbu", 1, 1, 0, 3'd4, 32'h103, 32'h0, 32'h80FF_FFFF, 1);
    checkOutput("lbu.const", rd_dm, 32'h0000_0080);
    applyStimulus("lh",  1, 1, 0, 3'd1, 32'h102, 32'h0, 32'hBEEF_1234, 1);
    checkOutput("lh.const", rd_dm, 32'hFFFF_BEEF);
    applyStimulus("lhu", 1, 1, 0, 3'd5, 32'h102, 32'h0, 32'hBEEF_1234, 2);
    checkOutput("lhu.const", rd_dm, 32'h0000_BEEF);
    applyStimulus("lw",  1, 1, 0, 3'd2, 32'h100, 32'h0, 32'hBEEF_1234, 1);
    checkOutput("lw.const", rd_dm, 32'hBEEF_1234);
    applyStimulus("sb",  1, 0, 1, 3'd0, 32'h101, 32'h1234_56AB, 32'h5555_AAAA, 1);
    checkOutput("sb.rd_unchanged", rd_dm, 32'hBEEF_1234);
    applyStimulus("sh_hi", 1, 0, 1, 3'd1, 32'h206, 32'hCAFE_F00D, 32'h0, 2);
    applyStimulus("sw",  1, 0, 1, 3'd2, 32'h300, 32'hDEAD_BEEF, 32'h0, 1);
    applyStimulus("lw_mis", 1, 1, 0, 3'd2, 32'h102, 32'h0, 32'h0, 1);
    applyStimulus("f3_011", 1, 1, 0, 3'd3, 32'h100, 32'h0, 32'h0, 1);
    applyStimulus("sbu_ill", 1, 0, 1, 3'd4, 32'h100, 32'h0, 32'h0, 1);
    applyStimulus("rdwr_ill", 1, 1, 1, 3'd2, 32'h100, 32'h0, 32'h0, 1);
    applyStimulus("lw_slow", 1, 1, 0, 3'd2, 32'h400, 32'h0, 32'h0BAD_F00D, 4);
    applyStimulus("b2b_0", 1, 1, 0, 3'd0, 32'h500, 32'h0, 32'h0000_007F, 1);
    applyStimulus("b2b_1", 1, 1, 0, 3'd1, 32'h502, 32'h0, 32'h8001_0000, 1);
    valid_in = 1'b0;

    // Reset during the second BUSY cycle of a load.
    @(negedge clk);
    valid_in  = 1'b1;
    mem_read  = 1'b1;
    mem_write = 1'b0;
    funct3    = 3'd2;
    addr      = 32'h600;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mid.busy1_req", dmem_req, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mid.busy2_req", dmem_req, 1'b1);
    rst      = 1'b1;
    valid_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    exp_rd = 32'h0;
    checkOutput("rst_mid.req", dmem_req, 1'b0);
    checkOutput("rst_mid.we", dmem_we, 1'b0);
    checkOutput("rst_mid.addr", dmem_addr, 32'h0);
    checkOutput("rst_mid.wdata", dmem_wdata, 32'h0);
    checkOutput("rst_mid.be", dmem_be, 4'b0000);
    checkOutput("rst_mid.rd_dm", rd_dm, 32'h0);
    checkOutput("rst_mid.done", lsu_done, 1'b0);
    checkOutput("rst_mid.stall", stall, 1'b0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h1357_9BDF;
    @(posedge clk);
    @(negedge clk);
    dmem_ack = 1'b0;
    checkOutput("late_ack.req", dmem_req, 1'b0);
    checkOutput("late_ack.done", lsu_done, 1'b0);
    checkOutput("late_ack.stall", stall, 1'b0);
    checkOutput("late_ack.rd_dm", rd_dm, 32'h0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("late_ack.done2", lsu_done, 1'b0);
    checkOutput("late_ack.rd_dm2", rd_dm, 32'h0);

    for (int i = 0; i < 120; i++) begin
      v  = ($urandom_range(0, 7) != 0);
      rd = 1'b0;
      wr = 1'b0;
      case ($urandom_range(0, 9))
        0: begin rd = 1'b1; wr = 1'b1; end
        1: begin rd = 1'b0; wr = 1'b0; end
        2, 3, 4, 5: rd = 1'b1;
        default: wr = 1'b1;
      endcase
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & 32'hFFFF_FFFC | 32'(f3 == 3'd0 || f3 == 3'd4 ? $urandom_range(0, 3) : (f3 == 3'd2 ? 0 : 2 * $urandom_range(0, 1)));
      applyStimulus($sformatf("rnd%0d", i), v, rd, wr, f3, a, $urandom, $urandom, $urandom_range(1, 4));
    end
    valid_in = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
